// File: rtl/plusarg_timeout_watchdog.sv
// plusarg_timeout_watchdog
// Simulation watchdog fed by a plusarg-derived cycle limit. It counts prescaled
// ticks while enabled, restarts on a progress kick, warns when the count nears
// the limit and latches a sticky expiry when the limit is reached. A limit of
// zero parks the block in DISABLED until the harness pulses clear.

module plusarg_timeout_watchdog #(
  parameter int unsigned PRESCALE_LOG2 = 0,
  parameter int unsigned WARN_SHIFT    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] limit,
  input  logic        enable,
  input  logic        kick,
  input  logic        clear,
  output logic [31:0] count,
  output logic        warn,
  output logic        expired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_WARN     = 3'd2,
    ST_EXPIRED  = 3'd3,
    ST_DISABLED = 3'd4
  } state_t;

  // The prescaler needs at least one bit even when no prescaling is requested;
  // with PRESCALE_LOG2 == 0 its terminal value is 0, so it never leaves 0 and
  // every enabled cycle is a tick.
  localparam int unsigned   PW       = (PRESCALE_LOG2 > 0) ? PRESCALE_LOG2 : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'((32'd1 << PRESCALE_LOG2) - 32'd1);

  state_t        state_q;
  logic [31:0]   count_q;
  logic [31:0]   limit_q;
  logic [31:0]   thr_q;
  logic [PW-1:0] prescaler_q;
  logic          warn_q;
  logic          expired_q;

  logic          pre_wrap;
  logic [PW-1:0] pre_next;
  logic          tick;
  logic [32:0]   count_inc;
  logic          hit_limit;
  logic          hit_thr;
  logic [31:0]   load_thr;

  // Tick generation and the compares against the sampled limit and threshold;
  // the compares are done one bit wider so count+1 can never wrap.
  always_comb begin
    pre_wrap  = (prescaler_q == PRE_LAST);
    pre_next  = pre_wrap ? '0 : (prescaler_q + PW'(1));
    tick      = enable && pre_wrap;
    count_inc = {1'b0, count_q} + 33'd1;
    hit_limit = (count_inc >= {1'b0, limit_q});
    hit_thr   = (count_inc >= {1'b0, thr_q});
    load_thr  = limit - (limit >> WARN_SHIFT);
  end

  // Watchdog state machine; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      count_q     <= '0;
      limit_q     <= '0;
      thr_q       <= '0;
      prescaler_q <= '0;
      warn_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          limit_q     <= limit;
          thr_q       <= load_thr;
          count_q     <= '0;
          prescaler_q <= '0;
          warn_q      <= 1'b0;
          expired_q   <= 1'b0;
          state_q     <= (limit == 32'd0) ? ST_DISABLED : ST_ARMED;
        end

        ST_ARMED, ST_WARN: begin
          if (kick) begin
            count_q     <= '0;
            prescaler_q <= '0;
            warn_q      <= 1'b0;
            state_q     <= ST_ARMED;
          end else begin
            if (enable) begin
              prescaler_q <= pre_next;
            end
            if (tick) begin
              if (hit_limit) begin
                count_q   <= limit_q;
                warn_q    <= 1'b1;
                expired_q <= 1'b1;
                state_q   <= ST_EXPIRED;
              end else if (hit_thr) begin
                count_q <= count_inc[31:0];
                warn_q  <= 1'b1;
                state_q <= ST_WARN;
              end else begin
                count_q <= count_inc[31:0];
              end
            end
          end
        end

        ST_EXPIRED: begin
          if (clear) begin
            count_q     <= '0;
            prescaler_q <= '0;
            warn_q      <= 1'b0;
            expired_q   <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end

        ST_DISABLED: begin
          count_q     <= '0;
          prescaler_q <= '0;
          warn_q      <= 1'b0;
          expired_q   <= 1'b0;
          if (clear) begin
            state_q <= ST_LOAD;
          end
        end

        default: begin
          count_q     <= '0;
          prescaler_q <= '0;
          warn_q      <= 1'b0;
          expired_q   <= 1'b0;
          state_q     <= ST_LOAD;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign warn    = warn_q;
  assign expired = expired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_plusarg_timeout_watchdog.sv
// tb_plusarg_timeout_watchdog
// Directed scoreboard bench: each step drives inputs, pushes the expected
// outputs for the following clock edge, then pops and compares after the edge.
// A second instance with a 4-clock prescaler covers the tick-rate behaviour.

module tb_plusarg_timeout_watchdog;

  localparam logic [2:0] S_LOAD     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_WARN     = 3'd2;
  localparam logic [2:0] S_EXPIRED  = 3'd3;
  localparam logic [2:0] S_DISABLED = 3'd4;

  logic        clock;
  logic        reset_n;
  logic [31:0] limit;
  logic        enable;
  logic        kick;
  logic        clear;
  logic [31:0] count;
  logic        warn;
  logic        expired;
  logic [2:0]  state;

  logic [31:0] limitP;
  logic        enableP;
  logic        kickP;
  logic        clearP;
  logic [31:0] countP;
  logic        warnP;
  logic        expiredP;
  logic [2:0]  stateP;

  typedef struct {
    string       tag;
    bit          inst;
    logic [31:0] count;
    logic        warn;
    logic        expired;
    logic [2:0]  state;
  } exp_t;

  exp_t sbq[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  plusarg_timeout_watchdog #(.PRESCALE_LOG2(0), .WARN_SHIFT(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .limit   (limit),
    .enable  (enable),
    .kick    (kick),
    .clear   (clear),
    .count   (count),
    .warn    (warn),
    .expired (expired),
    .state   (state)
  );

  plusarg_timeout_watchdog #(.PRESCALE_LOG2(2), .WARN_SHIFT(3)) dutP (
    .clock   (clock),
    .reset_n (reset_n),
    .limit   (limitP),
    .enable  (enableP),
    .kick    (kickP),
    .clear   (clearP),
    .count   (countP),
    .warn    (warnP),
    .expired (expiredP),
    .state   (stateP)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic expectOut(input string tag, input bit inst, input logic [31:0] c,
                           input logic w, input logic e, input logic [2:0] s);
    exp_t x;
    x.tag = tag; x.inst = inst; x.count = c; x.warn = w; x.expired = e; x.state = s;
    sbq.push_back(x);
  endtask

  task automatic applyStimulus(input logic en, input logic kk, input logic cl);
    enable = en;
    kick   = kk;
    clear  = cl;
  endtask

  task automatic checkOutput();
    exp_t        x;
    logic [31:0] oc;
    logic        ow;
    logic        oe;
    logic [2:0]  os;
    x = sbq.pop_front();
    if (x.inst) begin
      oc = countP; ow = warnP; oe = expiredP; os = stateP;
    end else begin
      oc = count; ow = warn; oe = expired; os = state;
    end
    checkCount++;
    assert (oc === x.count) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", x.tag, oc, x.count);
    end
    checkCount++;
    assert (ow === x.warn) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s warn observed=%b expected=%b", x.tag, ow, x.warn);
    end
    checkCount++;
    assert (oe === x.expired) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s expired observed=%b expected=%b", x.tag, oe, x.expired);
    end
    checkCount++;
    assert (os === x.state) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s state observed=%0d expected=%0d", x.tag, os, x.state);
    end
  endtask

  task automatic stepMain(input logic en, input logic kk, input logic cl,
                          input logic [31:0] c, input logic w, input logic e,
                          input logic [2:0] s, input string tag);
    applyStimulus(en, kk, cl);
    expectOut(tag, 1'b0, c, w, e, s);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic cycleNoCheck(input logic en, input logic kk, input logic cl);
    applyStimulus(en, kk, cl);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int mc;
    int pc;
    int pre;
    logic en;
    logic kk;
    logic cl;

    reset_n = 1'b0;
    limit   = 32'd10;
    applyStimulus(1'b0, 1'b0, 1'b0);
    limitP  = 32'd3;
    enableP = 1'b0;
    kickP   = 1'b0;
    clearP  = 1'b0;

    // Reset values on both instances
    #2;
    expectOut("reset", 1'b0, 32'd0, 1'b0, 1'b0, S_LOAD);
    checkOutput();
    expectOut("reset_p", 1'b1, 32'd0, 1'b0, 1'b0, S_LOAD);
    checkOutput();
    #20;
    reset_n = 1'b1;

    // Test 1: limit 10, threshold 9
    stepMain(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t1_armed");
    expectOut("t1_armed_p", 1'b1, 32'd0, 1'b0, 1'b0, S_ARMED);
    checkOutput();
    for (int k = 1; k <= 10; k++) begin
      stepMain(1'b1, 1'b0, 1'b0, 32'(k), (k >= 9), (k == 10),
               (k == 10) ? S_EXPIRED : ((k >= 9) ? S_WARN : S_ARMED), "t1_count");
    end
    stepMain(1'b1, 1'b1, 1'b0, 32'd10, 1'b1, 1'b1, S_EXPIRED, "t1_hold_kick");
    stepMain(1'b1, 1'b0, 1'b0, 32'd10, 1'b1, 1'b1, S_EXPIRED, "t1_hold_en");
    stepMain(1'b0, 1'b0, 1'b0, 32'd10, 1'b1, 1'b1, S_EXPIRED, "t1_hold_idle");

    // Test 3: limit 4, threshold equals limit; kick beats a same-cycle hit
    limit = 32'd4;
    cycleNoCheck(1'b1, 1'b0, 1'b1);
    stepMain(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t3_armed");
    for (int k = 1; k <= 3; k++) begin
      stepMain(1'b1, 1'b0, 1'b0, 32'(k), 1'b0, 1'b0, S_ARMED, "t3_count_a");
    end
    stepMain(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t3_kick_wins");
    for (int k = 1; k <= 3; k++) begin
      stepMain(1'b1, 1'b0, 1'b1, 32'(k), 1'b0, 1'b0, S_ARMED, "t3_count_b");
    end
    stepMain(1'b1, 1'b0, 1'b0, 32'd4, 1'b1, 1'b1, S_EXPIRED, "t3_expire");

    // Test 4: limit 0 disables; later re-armed with limit 5
    limit = 32'd0;
    cycleNoCheck(1'b0, 1'b0, 1'b1);
    stepMain(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_DISABLED, "t4_disabled");
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 1));
      kk = 1'($urandom_range(0, 1));
      stepMain(en, kk, 1'b0, 32'd0, 1'b0, 1'b0, S_DISABLED, "t4_idle");
    end
    limit = 32'd5;
    cycleNoCheck(1'b1, 1'b0, 1'b1);
    stepMain(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t4_rearmed");
    for (int k = 1; k <= 5; k++) begin
      stepMain(1'b1, 1'b0, 1'b0, 32'(k), (k == 5), (k == 5),
               (k == 5) ? S_EXPIRED : S_ARMED, "t4_count");
    end

    // Test 5: prescaled instance, limit 3, enable toggling every clock
    pc  = 0;
    pre = 0;
    for (int j = 0; j < 28; j++) begin
      en = (j % 2 == 1);
      enableP = en;
      if (pc < 3 && en) begin
        if (pre == 3) pc++;
        pre = (pre + 1) % 4;
      end
      expectOut("t5_prescale", 1'b1, 32'(pc), (pc >= 3), (pc >= 3),
                (pc >= 3) ? S_EXPIRED : S_ARMED);
      @(posedge clock);
      #1;
      checkOutput();
    end
    enableP = 1'b0;

    // Test 2: limit 100, kick every 50 cycles, clear ignored while armed
    limit = 32'd100;
    cycleNoCheck(1'b1, 1'b0, 1'b1);
    stepMain(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t2_armed");
    mc = 0;
    for (int i = 0; i < 2000; i++) begin
      kk = (i % 50 == 49);
      cl = (i % 97 == 0);
      mc = kk ? 0 : mc + 1;
      stepMain(1'b1, kk, cl, 32'(mc), 1'b0, 1'b0, S_ARMED, "t2_kick");
    end

    // Test 6: count into WARN (threshold 88), limit change ignored, then reset
    limit = 32'd3;
    for (int k = 1; k <= 90; k++) begin
      stepMain(1'b1, 1'b0, 1'b0, 32'(k), (k >= 88), 1'b0,
               (k >= 88) ? S_WARN : S_ARMED, "t6_count");
    end
    #2;
    reset_n = 1'b0;
    limit   = 32'd7;
    #1;
    expectOut("t6_in_reset", 1'b0, 32'd0, 1'b0, 1'b0, S_LOAD);
    checkOutput();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    stepMain(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, S_ARMED, "t6_rearmed");
    for (int k = 1; k <= 7; k++) begin
      stepMain(1'b1, 1'b0, 1'b0, 32'(k), (k == 7), (k == 7),
               (k == 7) ? S_EXPIRED : S_ARMED, "t6_recount");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
